uc_multiciclo: RTL and testbench

//  Multi-cycle control FSM for the MIPS-subset datapath. It sequences a shared ALU, one unified

---
 rtl/uc_multiciclo_if.sv | 34 +++
 rtl/uc_multiciclo.sv | 141 ++++++++++++++
 tb/tb_uc_multiciclo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uc_multiciclo_if.sv
// rtl/uc_multiciclo_if.sv - control bus between the multi-cycle FSM and the datapath/memory
interface uc_multiciclo_if;
  logic [5:0]  OP;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemToReg;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic        PCSource;
  logic        err;
  logic [31:0] retired;
  logic [3:0]  state;

  modport master (
    input  OP, Zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, err, retired, state
  );

  modport slave (
    output OP, Zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, err, retired, state
  );
endinterface

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multi-cycle MIPS-subset control FSM with memory handshake and timeout
module uc_multiciclo #(
  parameter int WAIT_LIMIT = 15
) (
  input logic             clk,
  input logic             rst,
  uc_multiciclo_if.master bus
);
  localparam int WW = $clog2(WAIT_LIMIT + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_MUL  = 6'b011100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  RWB    = 4'd7,
    EXEC_I = 4'd8,  IWB    = 4'd9,  BRANCH = 4'd10, HALT   = 4'd11
  } state_t;

  state_t        state, nextState;
  logic [5:0]    opQ;
  logic [WW-1:0] waitCnt;
  logic          errQ;
  logic [31:0]   retiredQ;
  logic          retire;
  logic          memState;
  logic          timeout;

  assign memState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // The last tolerated idle cycle: if memory is still not ready now, give up.
  assign timeout  = !bus.mem_ready && (waitCnt == WW'(WAIT_LIMIT - 1));

  always_comb begin
    nextState = state;
    retire    = 1'b0;
    case (state)
      FETCH:  if (bus.mem_ready) nextState = DECODE;
              else if (timeout)  nextState = HALT;
      DECODE: case (bus.OP)
                OP_LW, OP_SW:                      nextState = MEMADR;
                OP_R, OP_MUL:                      nextState = EXEC_R;
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nextState = EXEC_I;
                OP_BEQ:                            nextState = BRANCH;
                default:                           nextState = HALT;
              endcase
      MEMADR: nextState = (opQ == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) nextState = MEMWB;
              else if (timeout)  nextState = HALT;
      MEMWB:  begin nextState = FETCH; retire = 1'b1; end
      MEMWR:  if (bus.mem_ready) begin nextState = FETCH; retire = 1'b1; end
              else if (timeout)  nextState = HALT;
      EXEC_R: nextState = RWB;
      RWB:    begin nextState = FETCH; retire = 1'b1; end
      EXEC_I: nextState = IWB;
      IWB:    begin nextState = FETCH; retire = 1'b1; end
      BRANCH: begin nextState = FETCH; retire = 1'b1; end
      HALT:   nextState = HALT;
      default: nextState = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      opQ      <= 6'd0;
      waitCnt  <= '0;
      errQ     <= 1'b0;
      retiredQ <= 32'd0;
    end else begin
      state <= nextState;
      if (state == DECODE) opQ <= bus.OP;
      if (nextState != state)                waitCnt <= '0;
      else if (memState && !bus.mem_ready)   waitCnt <= waitCnt + 1'b1;
      if (nextState == HALT) errQ <= 1'b1;
      if (retire) retiredQ <= retiredQ + 32'd1;
    end
  end

  // Strobes are forced low during reset so nothing reaches memory mid-access.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 3'b000;
    bus.PCSource    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:  begin
                  bus.MemRead = 1'b1;
                  bus.ALUSrcB = 2'b01;
                  bus.IRWrite = bus.mem_ready;
                  bus.PCWrite = bus.mem_ready;
                end
        DECODE: bus.ALUSrcB = 2'b11;
        MEMADR: begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
        MEMRD:  begin bus.IorD = 1'b1; bus.MemRead = 1'b1; end
        MEMWB:  begin bus.MemToReg = 1'b1; bus.RegWrite = 1'b1; end
        MEMWR:  begin bus.IorD = 1'b1; bus.MemWrite = 1'b1; end
        EXEC_R: begin bus.ALUSrcA = 1'b1; bus.ALUOp = 3'b101; end
        RWB:    begin bus.RegDst = 1'b1; bus.RegWrite = 1'b1; end
        EXEC_I: begin
                  bus.ALUSrcA = 1'b1;
                  bus.ALUSrcB = 2'b10;
                  case (opQ)
                    OP_ANDI: bus.ALUOp = 3'b010;
                    OP_ORI:  bus.ALUOp = 3'b011;
                    OP_SLTI: bus.ALUOp = 3'b100;
                    default: bus.ALUOp = 3'b000;
                  endcase
                end
        IWB:    bus.RegWrite = 1'b1;
        BRANCH: begin
                  bus.ALUSrcA     = 1'b1;
                  bus.ALUOp       = 3'b001;
                  bus.PCWriteCond = 1'b1;
                  bus.PCSource    = 1'b1;
                end
        default: ;
      endcase
    end
  end

  assign bus.err     = errQ;
  assign bus.retired = retiredQ;
  assign bus.state   = state;
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - scoreboard bench: instruction-level model predicts per-cycle state and controls
module tb_uc_multiciclo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uc_multiciclo_if bus();
  uc_multiciclo #(.WAIT_LIMIT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, MUL = 6'b011100;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010, BAD = 6'b111111;

  typedef struct {
    int          st;
    logic [16:0] ctrl;
    logic        err;
    logic [31:0] ret;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  curOp = 6'd0;
  logic [31:0] modelRetired = 32'd0;
  logic        modelErr = 1'b0;
  logic [5:0]  legal[9] = '{LW, SW, RT, MUL, BEQ, ADDI, ANDI, ORI, SLTI};

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [16:0] expCtrl(input int st, input logic [5:0] op, input logic rdy);
    logic pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, psrc;
    logic [1:0] asb;
    logic [2:0] aop;
    {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, psrc} = '0;
    asb = 2'b00;
    aop = 3'b000;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin iod = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iod = 1; mwr = 1; end
      6:  begin asa = 1; aop = 3'b101; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin
            asa = 1; asb = 2'b10;
            aop = (op == ANDI) ? 3'b010 : (op == ORI) ? 3'b011 : (op == SLTI) ? 3'b100 : 3'b000;
          end
      9:  rw = 1;
      10: begin asa = 1; aop = 3'b001; pcc = 1; psrc = 1; end
      default: ;
    endcase
    return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  // One clock of stimulus plus the response the model expects in that cycle.
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.OP = op;
    bus.mem_ready = rdy;
    bus.Zero = 1'($urandom);
    if (r) begin
      modelRetired = 32'd0;
      modelErr = 1'b0;
    end
    if (!r && st == 11) modelErr = 1'b1;
    e.st   = r ? 0 : st;
    e.ctrl = r ? 17'd0 : expCtrl(st, curOp, rdy);
    e.err  = modelErr;
    e.ret  = modelRetired;
    q.push_back(e);
  endtask

  task automatic memPhase(input int st, input int waits);
    for (int i = 0; i < waits; i++) cyc(0, rnd6(), 1'b0, st);
    cyc(0, rnd6(), 1'b1, st);
  endtask

  task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
    memPhase(0, fw);
    curOp = op;
    cyc(0, op, 1'($urandom), 1);
    case (op)
      LW:        begin cyc(0, rnd6(), 1'($urandom), 2); memPhase(3, mw); cyc(0, rnd6(), 1'($urandom), 4); end
      SW:        begin cyc(0, rnd6(), 1'($urandom), 2); memPhase(5, mw); end
      RT, MUL:   begin cyc(0, rnd6(), 1'($urandom), 6); cyc(0, rnd6(), 1'($urandom), 7); end
      BEQ:       cyc(0, rnd6(), 1'($urandom), 10);
      default:   begin cyc(0, rnd6(), 1'($urandom), 8); cyc(0, rnd6(), 1'($urandom), 9); end
    endcase
    modelRetired = modelRetired + 32'd1;
  endtask

  task automatic haltAndReset();
    for (int i = 0; i < 3; i++) cyc(0, rnd6(), 1'($urandom), 11);
    cyc(1, rnd6(), 1'($urandom), 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [16:0] act;
      e = q.pop_front();
      act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
             bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};
      checks++;
      if (int'(bus.state) != e.st || act !== e.ctrl || bus.err !== e.err || bus.retired !== e.ret) begin
        errors++;
        $display("FAIL cycle t=%0t state act=%0d exp=%0d ctrl act=%h exp=%h err act=%b exp=%b retired act=%0d exp=%0d",
                 $time, bus.state, e.st, act, e.ctrl, bus.err, e.err, bus.retired, e.ret);
      end
    end
  end

  initial begin
    bus.OP = 6'd0;
    bus.mem_ready = 1'b0;
    bus.Zero = 1'b0;
    cyc(1, 6'd0, 1'b0, 0);
    cyc(1, 6'd0, 1'b1, 0);

    runInstr(LW, 0, 0);
    runInstr(ORI, 0, 0);
    runInstr(ADDI, 0, 0);
    runInstr(BEQ, 0, 0);
    runInstr(LW, 3, 0);
    runInstr(LW, 0, 14);
    runInstr(SW, 1, 2);
    runInstr(SLTI, 0, 0);
    runInstr(ANDI, 0, 0);
    runInstr(MUL, 0, 0);
    runInstr(RT, 2, 0);

    for (int n = 0; n < 60; n++)
      runInstr(legal[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset while a store is stalled in MEMWR.
    cyc(0, rnd6(), 1'b1, 0);
    curOp = SW;
    cyc(0, SW, 1'b0, 1);
    cyc(0, rnd6(), 1'b0, 2);
    cyc(0, rnd6(), 1'b0, 5);
    cyc(0, rnd6(), 1'b0, 5);
    cyc(1, rnd6(), 1'b0, 0);
    cyc(1, rnd6(), 1'b1, 0);

    for (int n = 0; n < 20; n++)
      runInstr(legal[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2));

    // Memory timeout in MEMRD.
    cyc(0, rnd6(), 1'b1, 0);
    curOp = LW;
    cyc(0, LW, 1'b0, 1);
    cyc(0, rnd6(), 1'b0, 2);
    for (int i = 0; i < 15; i++) cyc(0, rnd6(), 1'b0, 3);
    haltAndReset();

    runInstr(BEQ, 0, 0);
    runInstr(ADDI, 1, 0);

    // Illegal opcode.
    cyc(0, rnd6(), 1'b1, 0);
    curOp = BAD;
    cyc(0, BAD, 1'b1, 1);
    haltAndReset();
    runInstr(SW, 0, 1);

    begin
      int n = 0;
      while (q.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      if (q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain pending act=%0d exp=0", q.size());
      end
    end
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
